renderer_coord_recover: RTL and testbench

RENDERER_COORD_RECOVER -- requirements
Module: renderer_coord_recover

---
 rtl/renderer_pkg.sv | 20 ++
 rtl/renderer_coord_recover.sv | 131 +++++++++++++
 tb/tb_renderer_coord_recover.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/renderer_pkg.sv
// Shared types for the renderer coordinate scan: counter widths, the
// receiver FSM state, and the per-beat error event bundle.
package renderer_pkg;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

    // Packed MSB-first so the struct maps directly onto err_status[2:0].
    typedef struct packed {
        logic sof_mid;
        logic late_eol;
        logic early_eol;
    } err_evt_t;

endpackage

// File: rtl/renderer_coord_recover.sv
// Recovers (hcount, vcount) from a SOF/EOL-marked row-major pixel stream and
// re-emits each pixel with its coordinates through one output register stage.
module renderer_coord_recover
    import renderer_pkg::*;
#(
    parameter int START_X = 0,
    parameter int END_X   = 640,
    parameter int START_Y = 0,
    parameter int END_Y   = 480,
    parameter int DATA_W  = 16
) (
    input  logic                aclk,
    input  logic                rst_in,
    input  logic                s_tvalid,
    output logic                s_tready,
    input  logic [DATA_W-1:0]   s_tdata,
    input  logic                s_tuser,
    input  logic                s_tlast,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATA_W-1:0]   m_data,
    output logic [HCOUNT_W-1:0] m_hcount,
    output logic [VCOUNT_W-1:0] m_vcount,
    output logic                m_eof,
    input  logic                clear_err,
    output logic [2:0]          err_status
);

    localparam logic [HCOUNT_W-1:0] X_FIRST = HCOUNT_W'(START_X);
    localparam logic [HCOUNT_W-1:0] X_LAST  = HCOUNT_W'(END_X - 1);
    localparam logic [VCOUNT_W-1:0] Y_FIRST = VCOUNT_W'(START_Y);
    localparam logic [VCOUNT_W-1:0] Y_LAST  = VCOUNT_W'(END_Y - 1);

    state_t                state, state_nxt;
    logic [HCOUNT_W-1:0]   x, x_nxt, cx;
    logic [VCOUNT_W-1:0]   y, y_nxt, cy;
    logic                  acc, emit, at_end, wrap, eof;
    err_evt_t              evt;

    assign s_tready = !m_valid || m_ready;
    assign acc      = s_tvalid && s_tready;

    // cx/cy are the coordinates of the beat being accepted; SOF forces them
    // back to the region origin so EOL checks see the resynchronised column.
    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        cx        = x;
        cy        = y;
        emit      = 1'b0;
        at_end    = 1'b0;
        wrap      = 1'b0;
        eof       = 1'b0;
        evt       = '0;
        if (acc) begin
            if (s_tuser) begin
                cx          = X_FIRST;
                cy          = Y_FIRST;
                emit        = 1'b1;
                evt.sof_mid = (state == ACTIVE);
            end else begin
                emit = (state == ACTIVE);
            end
            if (emit) begin
                at_end        = (cx == X_LAST);
                wrap          = at_end || s_tlast;
                evt.early_eol = s_tlast && !at_end;
                evt.late_eol  = at_end && !s_tlast;
                eof           = wrap && (cy == Y_LAST);
                if (eof) begin
                    state_nxt = WAIT_SOF;
                    x_nxt     = X_FIRST;
                    y_nxt     = Y_FIRST;
                end else begin
                    state_nxt = ACTIVE;
                    if (wrap) begin
                        x_nxt = X_FIRST;
                        y_nxt = cy + VCOUNT_W'(1);
                    end else begin
                        x_nxt = cx + HCOUNT_W'(1);
                        y_nxt = cy;
                    end
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (rst_in) begin
            state <= WAIT_SOF;
            x     <= X_FIRST;
            y     <= Y_FIRST;
        end else begin
            state <= state_nxt;
            x     <= x_nxt;
            y     <= y_nxt;
        end
    end

    // Output stage: loads only on an emitted beat, otherwise holds until taken.
    always_ff @(posedge aclk) begin
        if (rst_in) begin
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_hcount <= X_FIRST;
            m_vcount <= Y_FIRST;
            m_eof    <= 1'b0;
        end else if (acc && emit) begin
            m_valid  <= 1'b1;
            m_data   <= s_tdata;
            m_hcount <= cx;
            m_vcount <= cy;
            m_eof    <= eof;
        end else if (m_ready) begin
            m_valid  <= 1'b0;
        end
    end

    // A fresh error event survives a simultaneous clear.
    always_ff @(posedge aclk) begin
        if (rst_in) begin
            err_status <= '0;
        end else if (clear_err) begin
            err_status <= evt;
        end else begin
            err_status <= err_status | evt;
        end
    end

endmodule

// File: tb/tb_renderer_coord_recover.sv
// Scoreboard bench for renderer_coord_recover on a 4x3 render region.
module tb_renderer_coord_recover;

    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [10:0]   h;
        logic [9:0]    v;
        logic          eof;
    } beat_t;

    logic          aclk = 1'b0;
    logic          rst_in = 1'b1;
    logic          s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          m_ready = 1'b1, clear_err = 1'b0;
    logic          s_tready, m_valid, m_eof;
    logic [DW-1:0] m_data;
    logic [10:0]   m_hcount;
    logic [9:0]    m_vcount;
    logic [2:0]    err_status;

    beat_t sb[$];
    beat_t mon_e;
    int    nchk = 0;
    int    nerr = 0;
    int    stalls = 0;

    renderer_coord_recover #(
        .START_X(0), .END_X(4), .START_Y(0), .END_Y(3), .DATA_W(DW)
    ) dut (
        .aclk(aclk), .rst_in(rst_in),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tuser(s_tuser), .s_tlast(s_tlast),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_hcount(m_hcount), .m_vcount(m_vcount), .m_eof(m_eof),
        .clear_err(clear_err), .err_status(err_status)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change at negedge; acceptance is sampled 1 time unit later.
    task automatic send(input logic [DW-1:0] d, input logic u, input logic l);
        bit ok;
        ok = 1'b0;
        s_tvalid = 1'b1; s_tdata = d; s_tuser = u; s_tlast = l;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1 ok = s_tready;
            if (!ok) stalls++;
            @(negedge aclk);
        end
        chk("send_accepted", 32'(ok), 32'd1);
        s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic u, input logic l,
                        input int h, input int v, input logic e);
        sb.push_back('{d: d, h: 11'(h), v: 10'(v), eof: e});
        send(d, u, l);
    endtask

    task automatic clean_frame(input logic [DW-1:0] base);
        for (int i = 0; i < 12; i++)
            beat(base + DW'(i), i == 0, (i % 4) == 3, i % 4, i / 4, i == 11);
    endtask

    task automatic drain();
        repeat (3) @(negedge aclk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic clear_and_check();
        clear_err = 1'b1;
        @(negedge aclk);
        clear_err = 1'b0;
        #1 chk("err_cleared", 32'(err_status), 32'd0);
    endtask

    // Output monitor: a beat transfers on the posedge after valid&ready is seen.
    initial forever begin
        @(negedge aclk);
        #2;
        if (!rst_in && m_valid && m_ready) begin
            chk("beat_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("m_data",   32'(m_data),   32'(mon_e.d));
                chk("m_hcount", 32'(m_hcount), 32'(mon_e.h));
                chk("m_vcount", 32'(m_vcount), 32'(mon_e.v));
                chk("m_eof",    32'(m_eof),    32'(mon_e.eof));
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge aclk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_eof", 32'(m_eof), 32'd0);
        chk("rst_m_hcount", 32'(m_hcount), 32'd0);
        chk("rst_m_vcount", 32'(m_vcount), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_err", 32'(err_status), 32'd0);
        @(negedge aclk);
        rst_in = 1'b0;
        #1 chk("rst_s_tready", 32'(s_tready), 32'd1);
        @(negedge aclk);

        // Clean frame at full rate
        stalls = 0;
        clean_frame(16'h1000);
        drain();
        chk("clean_no_stall", 32'(stalls), 32'd0);
        chk("clean_err", 32'(err_status), 32'd0);

        // Beats before SOF are discarded; first emitted beat has 1-cycle latency
        for (int i = 0; i < 3; i++) begin
            send(16'hDEAD, 1'b0, 1'b0);
            #1 chk("drop_no_valid", 32'(m_valid), 32'd0);
        end
        for (int i = 0; i < 12; i++) begin
            beat(16'h2000 + DW'(i), i == 0, (i % 4) == 3, i % 4, i / 4, i == 11);
            if (i == 0) begin
                #1;
                chk("latency_valid", 32'(m_valid), 32'd1);
                chk("latency_h", 32'(m_hcount), 32'd0);
            end
        end
        drain();
        chk("presof_err", 32'(err_status), 32'd0);

        // Early EOL on beat 2 of row 0
        beat(16'h3000, 1, 0, 0, 0, 0);
        beat(16'h3001, 0, 0, 1, 0, 0);
        beat(16'h3002, 0, 1, 2, 0, 0);
        for (int i = 0; i < 8; i++)
            beat(16'h3003 + DW'(i), 0, (i % 4) == 3, i % 4, 1 + i / 4, i == 7);
        drain();
        chk("early_eol_err", 32'(err_status), 32'b001);
        clear_and_check();

        // Missing EOL on every row: counters wrap on their own
        for (int i = 0; i < 12; i++)
            beat(16'h4000 + DW'(i), i == 0, 1'b0, i % 4, i / 4, i == 11);
        drain();
        chk("late_eol_err", 32'(err_status), 32'b010);
        clear_and_check();

        // SOF reasserted on beat 6 restarts at the origin
        for (int i = 0; i < 6; i++)
            beat(16'h5000 + DW'(i), i == 0, i == 3, i % 4, i / 4, 1'b0);
        beat(16'h5006, 1, 0, 0, 0, 0);
        for (int i = 1; i < 12; i++)
            beat(16'h5100 + DW'(i), 1'b0, (i % 4) == 3, i % 4, i / 4, i == 11);
        drain();
        chk("sof_mid_err", 32'(err_status), 32'b100);
        clear_and_check();

        // Downstream stall of 5 cycles mid-row
        beat(16'h6000, 1, 0, 0, 0, 0);
        beat(16'h6001, 0, 0, 1, 0, 0);
        m_ready = 1'b0;
        stalls = 0;
        fork
            beat(16'h6002, 0, 0, 2, 0, 0);
            begin
                repeat (5) begin
                    #1;
                    chk("stall_tready", 32'(s_tready), 32'd0);
                    chk("stall_valid", 32'(m_valid), 32'd1);
                    chk("stall_data", 32'(m_data), 32'h6001);
                    chk("stall_h", 32'(m_hcount), 32'd1);
                    chk("stall_v", 32'(m_vcount), 32'd0);
                    @(negedge aclk);
                end
                m_ready = 1'b1;
            end
        join
        chk("stall_cycles", 32'(stalls), 32'd5);
        for (int i = 3; i < 12; i++)
            beat(16'h6000 + DW'(i), 1'b0, (i % 4) == 3, i % 4, i / 4, i == 11);
        drain();
        chk("stall_err", 32'(err_status), 32'd0);

        // Reset during row 1 abandons the frame and clears errors
        beat(16'h7000, 1, 0, 0, 0, 0);
        beat(16'h7001, 0, 1, 1, 0, 0);
        beat(16'h7002, 0, 0, 0, 1, 0);
        beat(16'h7003, 0, 0, 1, 1, 0);
        rst_in = 1'b1;
        @(negedge aclk);
        rst_in = 1'b0;
        sb.delete();
        #1;
        chk("midrst_valid", 32'(m_valid), 32'd0);
        chk("midrst_err", 32'(err_status), 32'd0);
        chk("midrst_tready", 32'(s_tready), 32'd1);
        @(negedge aclk);
        clean_frame(16'h8000);
        drain();
        chk("postrst_err", 32'(err_status), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
